// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready handshake on both sides.
// Single-cycle ops complete one cycle after acceptance; unsigned multiply
// runs as a WIDTH-cycle shift-add loop. The result is held until taken.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               carry,
  output logic               overflow,
  output logic               err
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_NOT = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SLT = 4'b0110;
  localparam logic [3:0] OP_EQ  = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               overflow_q, overflow_d;
  logic               err_q, err_d;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [2*WIDTH-1:0] alu_result;
  logic               alu_carry;
  logic               alu_overflow;
  logic               alu_err;
  logic [2*WIDTH-1:0] prod_next;

  // Single-cycle ALU evaluated straight from the offered operands.
  always_comb begin
    add_sum      = {1'b0, a} + {1'b0, b};
    sub_diff     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    alu_err      = 1'b0;
    case (op)
      OP_ADD: begin
        alu_result   = {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
        alu_carry    = add_sum[WIDTH];
        alu_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_result   = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
        alu_carry    = sub_diff[WIDTH];
        alu_overflow = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT: alu_result = {{WIDTH{1'b0}}, ~a};
      OP_AND: alu_result = {{WIDTH{1'b0}}, a & b};
      OP_OR:  alu_result = {{WIDTH{1'b0}}, a | b};
      OP_XOR: alu_result = {{WIDTH{1'b0}}, a ^ b};
      OP_SLT: alu_result = {{(2*WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_EQ:  alu_result = {{(2*WIDTH-1){1'b0}}, (a == b)};
      OP_MUL: begin
        alu_result = '0;
      end
      default: alu_err = 1'b1;
    endcase
  end

  // One shift-add step: accumulate the multiplicand when the current multiplier LSB is set.
  always_comb begin
    prod_next = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
  end

  // Next-state logic for the handshake FSM and its datapath registers.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    result_d   = result_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            state_d  = BUSY;
            cnt_d    = '0;
            prod_d   = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
          end else begin
            state_d    = HOLD;
            result_d   = alu_result;
            zero_d     = (alu_result == '0);
            carry_d    = alu_carry;
            overflow_d = alu_overflow;
            err_d      = alu_err;
          end
        end
      end
      BUSY: begin
        prod_d   = prod_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d    = HOLD;
          result_d   = prod_next;
          zero_d     = (prod_next == '0);
          carry_d    = 1'b0;
          overflow_d = |prod_next[2*WIDTH-1:WIDTH];
          err_d      = 1'b0;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prod_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prod_q     <= prod_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and randomized checks of seq_alu against an
// arithmetic reference model, including latency, backpressure and reset abort.
module tb_seq_alu;

  localparam int W = 8;

  typedef struct packed {
    logic [2*W-1:0] res;
    logic           z;
    logic           c;
    logic           v;
    logic           e;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           zero;
  logic           carry;
  logic           overflow;
  logic           err;

  int   checkCount;
  int   passCount;
  exp_t lastObs;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .err       (err)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the DUT never finishes a handshake.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model computed from the arithmetic meaning of each opcode.
  function automatic exp_t refModel(input logic [3:0] opIn, input logic [W-1:0] aIn,
                                    input logic [W-1:0] bIn);
    longint full, half, ua, ub, sa, sb, r, s;
    exp_t   e;
    full = longint'(1) << W;
    half = full / 2;
    ua   = longint'(aIn);
    ub   = longint'(bIn);
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    e    = '0;
    r    = 0;
    s    = 0;
    case (opIn)
      4'd0: begin
        r   = (ua + ub) % full;
        e.c = ((ua + ub) >= full);
        s   = sa + sb;
        e.v = (s >= half) || (s < -half);
      end
      4'd1: begin
        r   = (ua - ub + full) % full;
        e.c = (ua >= ub);
        s   = sa - sb;
        e.v = (s >= half) || (s < -half);
      end
      4'd2: r = full - 1 - ua;
      4'd3: r = ua & ub;
      4'd4: r = ua | ub;
      4'd5: r = ua ^ ub;
      4'd6: r = (sa < sb) ? 64'd1 : 64'd0;
      4'd7: r = (ua == ub) ? 64'd1 : 64'd0;
      4'd8: begin
        r   = ua * ub;
        e.v = (r >= full);
      end
      default: e.e = 1'b1;
    endcase
    e.res = r[2*W-1:0];
    e.z   = (r == 0);
    return e;
  endfunction

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Offer one operation, track latency, check results, apply backpressure, then release.
  task automatic applyStimulus(input logic [3:0] opIn, input logic [W-1:0] aIn,
                               input logic [W-1:0] bIn, input int stallCycles);
    exp_t exp;
    exp_t obs;
    int   lat;
    int   expLat;
    logic sawReady;
    logic stable;
    exp    = refModel(opIn, aIn, bIn);
    expLat = (opIn == 4'b1000) ? W + 1 : 1;
    checkOutput("idle_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op       = opIn;
    a        = aIn;
    b        = bIn;
    @(posedge clk); #1;
    in_valid = 1'($urandom_range(0, 1));
    op       = 4'($urandom);
    a        = W'($urandom);
    b        = W'($urandom);
    lat      = 1;
    sawReady = 1'b0;
    while (!out_valid && lat <= W + 4) begin
      sawReady = sawReady | in_ready;
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      a        = W'($urandom);
      lat++;
    end
    checkOutput("latency", 64'(lat), 64'(expLat));
    if (!out_valid) begin
      in_valid = 1'b0;
      return;
    end
    if (opIn == 4'b1000) begin
      checkOutput("busy_in_ready", 64'(sawReady), 64'd0);
    end
    obs = {result, zero, carry, overflow, err};
    checkOutput("result", 64'(obs.res), 64'(exp.res));
    checkOutput("flags_zcve", 64'({obs.z, obs.c, obs.v, obs.e}),
                64'({exp.z, exp.c, exp.v, exp.e}));
    checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
    stable = 1'b1;
    for (int i = 0; i < stallCycles; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      op       = 4'($urandom);
      stable   = stable & out_valid & ~in_ready &
                 ({result, zero, carry, overflow, err} == obs);
    end
    if (stallCycles > 0) begin
      checkOutput("hold_stable", 64'(stable), 64'd1);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("release_valid_ready", 64'({out_valid, in_ready}), 64'b01);
    lastObs = obs;
  endtask

  // Main sequence: reset, directed vectors, reset abort, then random traffic.
  initial begin
    checkCount = 0;
    passCount  = 0;
    rst        = 1'b1;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    op         = 4'b0000;
    a          = 8'h11;
    b          = 8'h22;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset_outputs", 64'({out_valid, result, zero, carry, overflow, err}), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("no_accept_in_reset", 64'(out_valid), 64'd0);

    applyStimulus(4'b0000, 8'h7F, 8'h01, 0);
    checkOutput("add_7f_01_res", 64'(lastObs.res), 64'h0080);
    checkOutput("add_7f_01_flags", 64'({lastObs.z, lastObs.c, lastObs.v, lastObs.e}), 64'b0010);
    applyStimulus(4'b0001, 8'h05, 8'h05, 0);
    checkOutput("sub_5_5_flags", 64'({lastObs.z, lastObs.c, lastObs.v}), 64'b110);
    applyStimulus(4'b0001, 8'h80, 8'h01, 0);
    checkOutput("sub_80_01_res", 64'(lastObs.res), 64'h007F);
    checkOutput("sub_80_01_cv", 64'({lastObs.c, lastObs.v}), 64'b11);
    applyStimulus(4'b0110, 8'hFF, 8'h01, 0);
    checkOutput("slt_ff_01", 64'(lastObs.res), 64'd1);
    applyStimulus(4'b0111, 8'h3C, 8'h3C, 0);
    checkOutput("eq_3c_3c", 64'(lastObs.res), 64'd1);
    applyStimulus(4'b1011, 8'h12, 8'h34, 0);
    checkOutput("illegal_res_err_zero", 64'({lastObs.res, lastObs.e, lastObs.z}), 64'b11);
    applyStimulus(4'b1000, 8'hFF, 8'hFF, 5);
    checkOutput("mul_ff_ff_res", 64'(lastObs.res), 64'hFE01);
    checkOutput("mul_ff_ff_ovf", 64'(lastObs.v), 64'd1);

    in_valid = 1'b1;
    op       = 4'b1000;
    a        = 8'h33;
    b        = 8'h77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    op       = 4'b0000;
    @(posedge clk); #1;
    checkOutput("abort_outputs", 64'({out_valid, result, zero, carry, overflow, err}), 64'd0);
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_no_accept", 64'(out_valid), 64'd0);
    applyStimulus(4'b1000, 8'h0C, 8'h0A, 0);
    checkOutput("mul_0c_0a_res", 64'(lastObs.res), 64'h0078);
    checkOutput("mul_0c_0a_ovf", 64'(lastObs.v), 64'd0);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] rop;
      rop = (n % 5 == 0) ? 4'b1000 : 4'($urandom_range(0, 15));
      applyStimulus(rop, W'($urandom), W'($urandom), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
